switch_capture: RTL and testbench

SWITCH_CAPTURE -- requirements
Module: switch_capture

---
 rtl/switch_capture_if.sv | 20 ++
 rtl/switch_capture.sv | 74 +++++++
 tb/tb_switch_capture.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/switch_capture_if.sv
// switch_capture_if: raw switch inputs and debounced/captured operand outputs; cap_cnt present under CAPTURE_COUNT_EN
interface switch_capture_if;
  logic raw_a;
  logic raw_b;
  logic raw_key_n;
  logic db_a;
  logic db_b;
  logic op_a;
  logic op_b;
  logic cap_stb;
  logic op_valid;
`ifdef CAPTURE_COUNT_EN
  logic [7:0] cap_cnt;
  modport slave (input raw_a, raw_b, raw_key_n, output db_a, db_b, op_a, op_b, cap_stb, op_valid, cap_cnt);
  modport master (output raw_a, raw_b, raw_key_n, input db_a, db_b, op_a, op_b, cap_stb, op_valid, cap_cnt);
`else
  modport slave (input raw_a, raw_b, raw_key_n, output db_a, db_b, op_a, op_b, cap_stb, op_valid);
  modport master (output raw_a, raw_b, raw_key_n, input db_a, db_b, op_a, op_b, cap_stb, op_valid);
`endif
endinterface

// File: rtl/switch_capture.sv
// switch_capture: synchronize and debounce two operand switches and a key, capture operands on each key press; CAPTURE_COUNT_EN adds cap_cnt
module switch_capture #(
  parameter int DB_CYCLES = 50000,
  parameter int DB_W = 16
) (
  input logic CLOCK_50,
  input logic rst_n,
  switch_capture_if.slave sc
);
  localparam logic [2:0] INIT = 3'b100;
  localparam logic [DB_W-1:0] LIM = DB_W'(DB_CYCLES);
  typedef enum logic {IDLE, HELD} state_t;
  logic [2:0] raw, s1, s2, db;
  logic [DB_W-1:0] cnt [3];
  state_t state;
  logic stb, oa, ob, ov;
  assign raw = {sc.raw_key_n, sc.raw_b, sc.raw_a};
  // two-flop synchronizers; the key idles high (released)
  always_ff @(posedge CLOCK_50 or negedge rst_n)
    if (!rst_n) begin
      s1 <= INIT;
      s2 <= INIT;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  // per-channel debounce: count disagreeing cycles, flip when the run reaches DB_CYCLES
  always_ff @(posedge CLOCK_50 or negedge rst_n)
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) cnt[k] <= '0;
      db <= INIT;
    end else begin
      for (int k = 0; k < 3; k++)
        if (s2[k] == db[k]) cnt[k] <= '0;
        else if (cnt[k] + DB_W'(1) == LIM) begin
          cnt[k] <= '0;
          db[k] <= ~db[k];
        end else cnt[k] <= cnt[k] + DB_W'(1);
    end
`ifdef CAPTURE_COUNT_EN
  logic [7:0] cc;
  assign sc.cap_cnt = cc;
`endif
  // key FSM: one capture pulse per press, operands latched from pre-flip debounced levels
  always_ff @(posedge CLOCK_50 or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      stb <= 1'b0;
      oa <= 1'b0;
      ob <= 1'b0;
      ov <= 1'b0;
`ifdef CAPTURE_COUNT_EN
      cc <= '0;
`endif
    end else begin
      stb <= 1'b0;
      if (state == IDLE && !db[2]) begin
        state <= HELD;
        stb <= 1'b1;
        oa <= db[0];
        ob <= db[1];
        ov <= 1'b1;
`ifdef CAPTURE_COUNT_EN
        cc <= cc + 8'd1;
`endif
      end else if (state == HELD && db[2]) state <= IDLE;
    end
  assign sc.db_a = db[0];
  assign sc.db_b = db[1];
  assign sc.op_a = oa;
  assign sc.op_b = ob;
  assign sc.cap_stb = stb;
  assign sc.op_valid = ov;
endmodule

// File: tb/tb_switch_capture.sv
// tb_switch_capture: randomized and directed bench against a history-window reference model (DB_CYCLES=4)
module tb_switch_capture;
  localparam int DB = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errs = 0;
  int pulses;
  switch_capture_if sc ();
  switch_capture #(.DB_CYCLES(DB), .DB_W(16)) dut (.CLOCK_50(clk), .rst_n(rst_n), .sc(sc));
  always #5 clk = ~clk;
  logic [2:0] m_db;
  logic m_idle, m_stb, m_opa, m_opb, m_valid;
  logic [7:0] m_cnt;
  logic [2:0] hist [$];
  logic [2:0] obsq [$];
  int since [3];
  task automatic chk(input string tag, input logic [7:0] o, input logic [7:0] e);
    checks++;
    assert (o === e) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  task automatic model_reset();
    m_db = 3'b100;
    m_idle = 1'b1;
    m_stb = 1'b0;
    m_opa = 1'b0;
    m_opb = 1'b0;
    m_valid = 1'b0;
    m_cnt = 8'd0;
    hist = {3'b100, 3'b100};
    obsq = {};
    for (int c = 0; c < 3; c++) since[c] = 0;
  endtask
  task automatic model_step(input logic [2:0] r);
    logic ok;
    m_stb = m_idle && !m_db[2];
    if (m_stb) begin
      m_opa = m_db[0];
      m_opb = m_db[1];
      m_valid = 1'b1;
      m_cnt = m_cnt + 8'd1;
    end
    if (m_idle && !m_db[2]) m_idle = 1'b0;
    else if (!m_idle && m_db[2]) m_idle = 1'b1;
    hist.push_back(r);
    obsq.push_back(hist[hist.size()-3]);
    for (int c = 0; c < 3; c++)
      if (obsq.size() - since[c] >= DB) begin
        ok = 1'b1;
        for (int j = obsq.size() - DB; j < obsq.size(); j++)
          if (obsq[j][c] == m_db[c]) ok = 1'b0;
        if (ok) begin
          m_db[c] = ~m_db[c];
          since[c] = obsq.size();
        end
      end
  endtask
  task automatic check_all(input string tag);
    chk({tag, ".db_a"}, {7'd0, sc.db_a}, {7'd0, m_db[0]});
    chk({tag, ".db_b"}, {7'd0, sc.db_b}, {7'd0, m_db[1]});
    chk({tag, ".op_a"}, {7'd0, sc.op_a}, {7'd0, m_opa});
    chk({tag, ".op_b"}, {7'd0, sc.op_b}, {7'd0, m_opb});
    chk({tag, ".cap_stb"}, {7'd0, sc.cap_stb}, {7'd0, m_stb});
    chk({tag, ".op_valid"}, {7'd0, sc.op_valid}, {7'd0, m_valid});
`ifdef CAPTURE_COUNT_EN
    chk({tag, ".cap_cnt"}, sc.cap_cnt, m_cnt);
`endif
  endtask
  task automatic tick(input string tag);
    logic [2:0] r;
    r = {sc.raw_key_n, sc.raw_b, sc.raw_a};
    @(posedge clk);
    model_step(r);
    #1;
    if (sc.cap_stb === 1'b1) pulses++;
    check_all(tag);
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    check_all("reset_hold");
    rst_n = 1'b1;
    pulses = 0;
  endtask
  initial begin
    sc.raw_a = 1'b0;
    sc.raw_b = 1'b0;
    sc.raw_key_n = 1'b1;
    @(posedge clk);
    #1;
    do_reset();
    sc.raw_key_n = 1'b0;
    repeat (3) tick("short_key");
    sc.raw_key_n = 1'b1;
    repeat (10) tick("short_key_rel");
    chk("short_no_valid", {7'd0, sc.op_valid}, 8'd0);
    chk("short_no_pulse", 8'(pulses), 8'd0);
    do_reset();
    sc.raw_a = 1'b1;
    repeat (5) tick("db_a_rise");
    chk("db_a_edge5", {7'd0, sc.db_a}, 8'd0);
    tick("db_a_rise");
    chk("db_a_edge6", {7'd0, sc.db_a}, 8'd1);
    chk("op_a_edge6", {7'd0, sc.op_a}, 8'd0);
    sc.raw_key_n = 1'b0;
    repeat (6) tick("press");
    chk("stb_edge6", {7'd0, sc.cap_stb}, 8'd0);
    tick("press");
    chk("stb_edge7", {7'd0, sc.cap_stb}, 8'd1);
    chk("op_a_cap", {7'd0, sc.op_a}, 8'd1);
    chk("op_b_cap", {7'd0, sc.op_b}, 8'd0);
    chk("valid_cap", {7'd0, sc.op_valid}, 8'd1);
    tick("press");
    chk("stb_edge8", {7'd0, sc.cap_stb}, 8'd0);
    repeat (92) tick("hold");
    sc.raw_key_n = 1'b1;
    repeat (10) tick("release");
    sc.raw_key_n = 1'b0;
    repeat (10) tick("press2");
    chk("two_pulses", 8'(pulses), 8'd2);
`ifdef CAPTURE_COUNT_EN
    chk("cap_cnt_two", sc.cap_cnt, 8'd2);
`endif
    sc.raw_key_n = 1'b1;
    do_reset();
    sc.raw_key_n = 1'b0;
    repeat (4) tick("mid_press");
    sc.raw_key_n = 1'b1;
    do_reset();
    chk("mid_rst_valid", {7'd0, sc.op_valid}, 8'd0);
    repeat (20) tick("after_mid_rst");
    chk("mid_rst_no_pulse", 8'(pulses), 8'd0);
    for (int s = 0; s < 300; s++) begin
      sc.raw_a = 1'($urandom);
      sc.raw_b = 1'($urandom);
      sc.raw_key_n = 1'($urandom);
      repeat ($urandom_range(1, 9)) tick("random");
    end
    sc.raw_key_n = 1'b1;
    do_reset();
    for (int p = 0; p < 256; p++) begin
      sc.raw_a = 1'($urandom);
      sc.raw_b = 1'($urandom);
      sc.raw_key_n = 1'b0;
      repeat (7) tick("wrap_press");
      sc.raw_key_n = 1'b1;
      repeat (7) tick("wrap_release");
    end
    chk("wrap_pulses", 8'(pulses), 8'(256));
`ifdef CAPTURE_COUNT_EN
    chk("cap_cnt_wrap", sc.cap_cnt, 8'd0);
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
